// File: rtl/reset_ctrl_pkg.sv
// reset_ctrl_pkg
//   Shared types and helpers for the reset controller.
//   state_t : controller FSM states
//   cause_t : encoding presented on reset_cause
//   sat_inc : saturating 8-bit increment used by the reset counter
package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        POR      = 2'd0,
        RUN      = 2'd1,
        HOLD_BTN = 2'd2,
        STRETCH  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_BTN  = 2'd1,
        CAUSE_TRAP = 2'd2
    } cause_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_ctrl_debounce.sv
// debounce
//   Synchronizes an asynchronous, bouncing active-low input and accepts a new
//   level only after CYCLES consecutive samples that differ from the current
//   accepted level.
// Ports
//   clk      in  1  sampling clock
//   reset_n  in  1  asynchronous active-low reset (sync flops and level -> 1)
//   in_n     in  1  raw active-low input, asynchronous to clk
//   level_n  out 1  debounced level (1 = released)
module debounce #(
    parameter int CYCLES = 40000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_n,
    output logic level_n
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= in_n;
            sync2 <= sync1;
        end
    end

    // The CYCLES-th consecutive differing sample is the one seen while the
    // counter holds CYCLES-1, so the level flips on that same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync2 != level) begin
            if (cnt == CW'(CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level_n = level;

endmodule

// File: rtl/reset_ctrl.sv
// reset_ctrl
//   Generates the system reset from a timed power-on pulse, the debounced
//   reset button and (optionally) a restart on trap. Tracks the cause of the
//   last reset and a saturating count of button/trap resets.
// Ports
//   clk             in  1  system clock
//   reset_n         in  1  asynchronous active-low reset
//   btn_n           in  1  raw reset button, active-low, bouncing
//   trap            in  1  trap level from system, sampled only in RUN
//   power_on_reset  out 1  active-high reset to system
//   reset_cause     out 2  0 POR, 1 BTN, 2 TRAP
//   reset_count     out 8  BTN+TRAP resets since reset_n, saturating at 255
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 40000,
    parameter int RESET_CYCLES    = 16,
    parameter int TRAP_RESTART    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       trap,
    output logic       power_on_reset,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int SW = $clog2(RESET_CYCLES + 1);

    state_t        state;
    cause_t        cause;
    logic [SW-1:0] stretch;
    logic          btn_level_n;

    debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .in_n   (btn_n),
        .level_n(btn_level_n)
    );

    // A debounced press is checked before the stretch count in every state
    // that can see one, so a press always restarts the cycle via HOLD_BTN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= POR;
            power_on_reset <= 1'b1;
            cause          <= CAUSE_POR;
            reset_count    <= '0;
            stretch        <= '0;
        end else begin
            case (state)
                POR: begin
                    if (!btn_level_n) begin
                        state       <= HOLD_BTN;
                        cause       <= CAUSE_BTN;
                        reset_count <= sat_inc(reset_count);
                        stretch     <= '0;
                    end else if (stretch == SW'(RESET_CYCLES - 1)) begin
                        state          <= RUN;
                        power_on_reset <= 1'b0;
                        stretch        <= '0;
                    end else begin
                        stretch <= stretch + SW'(1);
                    end
                end

                RUN: begin
                    if (!btn_level_n) begin
                        state          <= HOLD_BTN;
                        power_on_reset <= 1'b1;
                        cause          <= CAUSE_BTN;
                        reset_count    <= sat_inc(reset_count);
                        stretch        <= '0;
                    end else if (trap && (TRAP_RESTART != 0)) begin
                        state          <= STRETCH;
                        power_on_reset <= 1'b1;
                        cause          <= CAUSE_TRAP;
                        reset_count    <= sat_inc(reset_count);
                        stretch        <= '0;
                    end
                end

                HOLD_BTN: begin
                    power_on_reset <= 1'b1;
                    stretch        <= '0;
                    if (btn_level_n) begin
                        state <= STRETCH;
                    end
                end

                STRETCH: begin
                    if (!btn_level_n) begin
                        state       <= HOLD_BTN;
                        cause       <= CAUSE_BTN;
                        reset_count <= sat_inc(reset_count);
                        stretch     <= '0;
                    end else if (stretch == SW'(RESET_CYCLES - 1)) begin
                        state          <= RUN;
                        power_on_reset <= 1'b0;
                        stretch        <= '0;
                    end else begin
                        stretch <= stretch + SW'(1);
                    end
                end

                default: begin
                    state          <= POR;
                    power_on_reset <= 1'b1;
                    stretch        <= '0;
                end
            endcase
        end
    end

    assign reset_cause = cause;

endmodule

// File: tb/tb_reset_ctrl.sv
module tb_reset_ctrl;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       btn_n   = 1'b1;
    logic       trap    = 1'b0;
    logic       power_on_reset;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        int unsigned at;
        string       name;
        logic        por;
        logic [1:0]  cause;
        logic [7:0]  count;
    } exp_t;

    exp_t sb[$];

    reset_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .RESET_CYCLES   (4),
        .TRAP_RESTART   (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_n         (btn_n),
        .trap          (trap),
        .power_on_reset(power_on_reset),
        .reset_cause   (reset_cause),
        .reset_count   (reset_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expect outputs por/cause/count at the falling edge dly posedges from now.
    task automatic push(input string name, input int unsigned dly, input logic por,
                        input logic [1:0] cause, input logic [7:0] count);
        exp_t e;
        e.at    = cyc + dly;
        e.name  = name;
        e.por   = por;
        e.cause = cause;
        e.count = count;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops every expectation that has come due and compares.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (e.at != cyc || power_on_reset !== e.por || reset_cause !== e.cause ||
                reset_count !== e.count) begin
                n_fail++;
                $display("FAIL %s @cyc %0d (due %0d): por=%0b cause=%0d count=%0d, expected por=%0b cause=%0d count=%0d",
                         e.name, cyc, e.at, power_on_reset, reset_cause, reset_count,
                         e.por, e.cause, e.count);
            end
        end
    end

    initial begin
        #1 reset_n = 1'b0;

        // 1: power-on pulse
        wait_cyc(2);
        push("rst_hold", 1, 1'b1, 2'd0, 8'd0);
        wait_cyc(1);
        reset_n = 1'b1;
        push("por_last", 3, 1'b1, 2'd0, 8'd0);
        push("por_done", 4, 1'b0, 2'd0, 8'd0);
        wait_cyc(10);

        // 2: clean press for 30 cycles
        btn_n = 1'b0;
        push("press_pre", 10, 1'b0, 2'd0, 8'd0);
        push("press",     11, 1'b1, 2'd1, 8'd1);
        wait_cyc(30);
        btn_n = 1'b1;
        push("rel_hold", 14, 1'b1, 2'd1, 8'd1);
        push("rel_done", 15, 1'b0, 2'd1, 8'd1);
        wait_cyc(20);

        // 3: glitches shorter than the debounce window
        push("glitch_a", 11, 1'b0, 2'd1, 8'd1);
        push("glitch_b", 19, 1'b0, 2'd1, 8'd1);
        push("glitch_c", 27, 1'b0, 2'd1, 8'd1);
        btn_n = 1'b0;
        wait_cyc(7);
        btn_n = 1'b1;
        wait_cyc(1);
        btn_n = 1'b0;
        wait_cyc(7);
        btn_n = 1'b1;
        wait_cyc(20);

        // 4: trap restarts from a fresh reset
        reset_n = 1'b0;
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(10);
        trap = 1'b1;
        push("trap_on",   1, 1'b1, 2'd2, 8'd1);
        push("trap_last", 4, 1'b1, 2'd2, 8'd1);
        push("trap_done", 5, 1'b0, 2'd2, 8'd1);
        wait_cyc(1);
        trap = 1'b0;
        wait_cyc(10);
        trap = 1'b1;
        push("trap_h1",     1, 1'b1, 2'd2, 8'd2);
        push("trap_h_run",  5, 1'b0, 2'd2, 8'd2);
        push("trap_h2",     6, 1'b1, 2'd2, 8'd3);
        push("trap_h2_end", 10, 1'b0, 2'd2, 8'd3);
        wait_cyc(6);
        trap = 1'b0;
        wait_cyc(10);

        // 5: press and trap seen in the same cycle
        btn_n = 1'b0;
        push("both",      11, 1'b1, 2'd1, 8'd4);
        push("both_once", 13, 1'b1, 2'd1, 8'd4);
        wait_cyc(10);
        trap = 1'b1;
        wait_cyc(1);
        trap = 1'b0;
        wait_cyc(9);
        btn_n = 1'b1;
        push("both_done", 15, 1'b0, 2'd1, 8'd4);
        wait_cyc(20);

        // 6: reset in HOLD_BTN with count=200, then saturation
        reset_n = 1'b0;
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(10);
        trap = 1'b1;
        wait_cyc(993);
        trap = 1'b0;
        wait_cyc(7);
        push("cnt199", 1, 1'b0, 2'd2, 8'd199);
        btn_n = 1'b0;
        push("cnt200", 11, 1'b1, 2'd1, 8'd200);
        wait_cyc(15);
        reset_n = 1'b0;
        push("rst_mid", 1, 1'b1, 2'd0, 8'd0);
        btn_n = 1'b1;
        wait_cyc(2);
        reset_n = 1'b1;
        push("rst_por_hi", 3, 1'b1, 2'd0, 8'd0);
        push("rst_por",    4, 1'b0, 2'd0, 8'd0);
        wait_cyc(10);

        trap = 1'b1;
        push("sat_254",   1266, 1'b1, 2'd2, 8'd254);
        push("sat_255",   1271, 1'b1, 2'd2, 8'd255);
        push("sat_hold",  1498, 1'b1, 2'd2, 8'd255);
        push("sat_final", 1515, 1'b0, 2'd2, 8'd255);
        wait_cyc(1510);
        trap = 1'b0;
        wait_cyc(15);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d expectations pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
